// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream
//   Signed fixed-point multiply-accumulate for one neuron output. It accepts
//   N_INPUTS (value, weight) pairs over a valid/ready handshake and adds a bias
//   that is captured on the first beat. The sum is rescaled by FRAC_W and
//   saturated to DATA_W, with optional ReLU. The unit then holds the result on
//   a valid/ready output and restarts for the next neuron once it is taken.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   clear      synchronous abort: drop the partial neuron and return to ACCUM
//   in_valid   value/weight/bias valid
//   in_ready   unit can accept a pair this cycle
//   value      signed activation (DATA_W)
//   weight     signed weight (DATA_W)
//   bias       signed bias, sampled only on the first accepted beat
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out        saturated, rescaled result (DATA_W)
//   overflow   result was saturated; meaningful only while out_valid=1
module neuron_mac_stream #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 40,
    parameter int RELU_EN  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] value,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     overflow
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_t;

    state_t                     state;
    logic [CNT_W-1:0]           count;
    logic [1:0]                 drain_cnt;
    logic                       accept;

    logic signed [2*DATA_W-1:0] mult_p0;
    logic signed [2*DATA_W-1:0] prod_p1;
    logic                       vld_p1;
    logic                       first_p1;
    logic signed [DATA_W-1:0]   bias_p1;
    logic signed [ACC_W-1:0]    acc_p2;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic [DATA_W:0]            sat_res;

    // Rescale, saturate, then apply ReLU. Returns {overflow, result}.
    // ReLU runs last, so a negative saturation reports 0 without overflow.
    function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        logic [ACC_W-DATA_W:0]   hi;
        logic [DATA_W-1:0]       res;
        logic                    ovf;
        r  = a >>> FRAC_W;
        hi = r[ACC_W-1:DATA_W-1];
        // The value fits when every bit from the DATA_W sign bit upward agrees.
        if (hi == '0 || hi == '1) begin
            res = r[DATA_W-1:0];
            ovf = 1'b0;
        end else if (r[ACC_W-1]) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
            ovf = 1'b1;
        end else begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
            ovf = 1'b1;
        end
        if (RELU_EN != 0 && res[DATA_W-1]) begin
            res = '0;
            ovf = 1'b0;
        end
        return {ovf, res};
    endfunction

    // A beat is refused during clear and while reset is held.
    assign in_ready = reset & ~clear & (state == ACCUM);
    assign accept   = in_valid & in_ready;

    always_comb begin
        mult_p0  = (2*DATA_W)'(value) * (2*DATA_W)'(weight);
        prod_ext = ACC_W'(prod_p1);
        bias_ext = ACC_W'(bias_p1) <<< FRAC_W;
        sat_res  = saturate(acc_p2);
    end

    // Stage 0 -> 1: register the product of the accepted beat.
    // Stage 1 -> 2: reload on the first beat of a neuron, otherwise accumulate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            prod_p1  <= '0;
            bias_p1  <= '0;
            acc_p2   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                prod_p1  <= mult_p0;
                first_p1 <= (count == '0);
                if (count == '0)
                    bias_p1 <= bias;
            end
            if (vld_p1)
                acc_p2 <= first_p1 ? (bias_ext + prod_ext) : (acc_p2 + prod_ext);
        end
    end

    // Control FSM. DRAIN lets the last product clear both stages before the
    // result is registered, giving out_valid three edges after the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACCUM;
            count     <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            count     <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (count == LAST_BEAT) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state     <= RESULT;
                        out_valid <= 1'b1;
                        out       <= sat_res[DATA_W-1:0];
                        overflow  <= sat_res[DATA_W];
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        count     <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_stream.sv
module tb_neuron_mac_stream;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int N      = 4;
    localparam int ACC_W  = 40;

    logic clk = 1'b0;
    logic reset, clear, in_valid, out_ready;
    logic signed [DATA_W-1:0] value, weight, bias;

    logic in_ready_r, out_valid_r, ovf_r;
    logic in_ready_l, out_valid_l, ovf_l;
    logic signed [DATA_W-1:0] out_r, out_l;

    always #5 clk = ~clk;

    neuron_mac_stream #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_INPUTS(N),
                        .ACC_W(ACC_W), .RELU_EN(1)) dut_relu (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_r), .value(value), .weight(weight), .bias(bias),
        .out_valid(out_valid_r), .out_ready(out_ready), .out(out_r),
        .overflow(ovf_r));

    neuron_mac_stream #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_INPUTS(N),
                        .ACC_W(ACC_W), .RELU_EN(0)) dut_lin (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_l), .value(value), .weight(weight), .bias(bias),
        .out_valid(out_valid_l), .out_ready(out_ready), .out(out_l),
        .overflow(ovf_l));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Operands of the neuron currently being driven.
    logic signed [DATA_W-1:0] vq [N];
    logic signed [DATA_W-1:0] wq [N];
    logic signed [DATA_W-1:0] bq;

    // Reference: exact integer sum, floor divide by 2^FRAC_W, clamp, ReLU.
    task automatic model(input bit relu, output logic [DATA_W-1:0] o, output logic ovf);
        longint acc, r;
        acc = longint'(bq) * (longint'(1) << FRAC_W);
        for (int i = 0; i < N; i++)
            acc += longint'(vq[i]) * longint'(wq[i]);
        r = acc >>> FRAC_W;
        if (r > 32767) begin
            o = 16'h7FFF; ovf = 1'b1;
        end else if (r < -32768) begin
            o = 16'h8000; ovf = 1'b1;
        end else begin
            o = 16'(r); ovf = 1'b0;
        end
        if (relu && r < 0) begin
            o = 16'h0000; ovf = 1'b0;
        end
    endtask

    // Drive beats [first, last) with up to max_gap idle cycles before each.
    // Called and returns #1 after a rising edge.
    task automatic send_beats(input int first, input int last, input int max_gap);
        for (int i = first; i < last; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
            value    = vq[i];
            weight   = wq[i];
            bias     = (i == 0) ? bq : 16'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            check("beat_in_ready", {31'd0, in_ready_r}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            value    = 16'($urandom);
            weight   = 16'($urandom);
            bias     = 16'($urandom);
        end
    endtask

    // After the last accepted beat: check latency, the result against the
    // model, a stalled output for `hold` cycles, then the handshake.
    task automatic finish_neuron(input int hold);
        logic [DATA_W-1:0] eo_r, eo_l;
        logic ev_r, ev_l;
        model(1'b1, eo_r, ev_r);
        model(1'b0, eo_l, ev_l);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("drain_out_valid", {31'd0, out_valid_r}, 32'd0);
            check("drain_in_ready", {31'd0, in_ready_r}, 32'd0);
        end
        @(posedge clk); #1;
        check("latency_out_valid", {31'd0, out_valid_r}, 32'd1);
        check("lin_out_valid", {31'd0, out_valid_l}, 32'd1);
        check("relu_out", {16'd0, out_r}, {16'd0, eo_r});
        check("relu_ovf", {31'd0, ovf_r}, {31'd0, ev_r});
        check("lin_out", {16'd0, out_l}, {16'd0, eo_l});
        check("lin_ovf", {31'd0, ovf_l}, {31'd0, ev_l});
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            value    = 16'($urandom);
            weight   = 16'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", {31'd0, out_valid_r}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready_r}, 32'd0);
            check("hold_out", {16'd0, out_l}, {16'd0, eo_l});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_out_valid", {31'd0, out_valid_r}, 32'd0);
        check("handshake_in_ready", {31'd0, in_ready_r}, 32'd1);
    endtask

    task automatic fill(input logic [15:0] v, input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < N; i++) begin
            vq[i] = v;
            wq[i] = w;
        end
        bq = b;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        value = '0; weight = '0; bias = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready_r}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid_r}, 32'd0);
        check("rst_out", {16'd0, out_r}, 32'd0);
        check("rst_ovf", {31'd0, ovf_r}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 1.0 * 2.0 accumulated four times
        fill(16'h0100, 16'h0200, 16'h0000);
        send_beats(0, N, 0); finish_neuron(0);
        check("t1_const", {16'd0, out_r}, 32'h0800);

        // bias 0.5, with junk bias on later beats; stall output 5 cycles
        fill(16'h0100, 16'h0200, 16'h0080);
        send_beats(0, N, 0); finish_neuron(5);
        check("t2_const", {16'd0, out_r}, 32'h0880);

        // positive and negative saturation
        fill(16'h7FFF, 16'h7FFF, 16'h0000);
        send_beats(0, N, 0); finish_neuron(0);
        check("t3_pos_sat", {16'd0, out_l}, 32'h7FFF);
        fill(16'h8000, 16'h7FFF, 16'h0000);
        send_beats(0, N, 0); finish_neuron(0);
        check("t3_neg_sat", {16'd0, out_l}, 32'h8000);
        check("t3_neg_relu", {16'd0, out_r}, 32'h0000);

        // -1.0 * 1.0 four times
        fill(16'hFF00, 16'h0100, 16'h0000);
        send_beats(0, N, 0); finish_neuron(0);
        check("t4_lin", {16'd0, out_l}, 32'hFC00);

        // async reset mid-neuron while a previous result is still held on out
        fill(16'h0100, 16'h0200, 16'h0080);
        send_beats(0, N, 0); finish_neuron(0);
        send_beats(0, 2, 0);
        #2 reset = 1'b0;
        #1;
        check("arst_out", {16'd0, out_l}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid_l}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready_l}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        fill(16'h0300, 16'h0100, 16'hFF80);
        send_beats(0, N, 0); finish_neuron(0);

        // clear after two beats, with a beat offered in the clear cycle
        fill(16'h7000, 16'h7000, 16'h1234);
        send_beats(0, 2, 0);
        clear = 1'b1; in_valid = 1'b1; value = 16'h0100; weight = 16'h0100;
        @(negedge clk);
        check("clear_in_ready", {31'd0, in_ready_r}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        fill(16'h0080, 16'h0400, 16'h0010);
        send_beats(0, N, 1); finish_neuron(1);

        // random neurons, mixing small operands and full-range ones
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < N; i++) begin
                if (n % 2 == 0) begin
                    vq[i] = 16'($urandom_range(0, 2047) - 1024);
                    wq[i] = 16'($urandom_range(0, 2047) - 1024);
                end else begin
                    vq[i] = 16'($urandom);
                    wq[i] = 16'($urandom);
                end
            end
            bq = 16'($urandom);
            send_beats(0, N, 2);
            finish_neuron($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
